// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator with built-in test patterns.
// All video outputs are registered together from one (h_cnt, v_cnt) sample.
module vga_timing_gen (
   input  logic       clk_25,
   input  logic       rst,
   input  logic       run,
   input  logic [1:0] pattern_sel,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic       vga_vde,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       frame_start,
   output logic       line_start
);

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_BP     = 10'd48;
   localparam logic [9:0] H_MAX    = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
   localparam logic [9:0] HS_FIRST = H_ACTIVE + H_FP;
   localparam logic [9:0] HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 10'd1;

   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_BP     = 10'd33;
   localparam logic [9:0] V_MAX    = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
   localparam logic [9:0] VS_FIRST = V_ACTIVE + V_FP;
   localparam logic [9:0] VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 10'd1;

   localparam logic [1:0] PAT_BLACK = 2'b00;
   localparam logic [1:0] PAT_BARS  = 2'b01;
   localparam logic [1:0] PAT_WHITE = 2'b10;

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [1:0]  pattern_q, pattern_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        vde_q, vde_d;
   logic [11:0] rgb_q, rgb_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [9:0]  pix_y_q, pix_y_d;
   logic        frame_start_q, frame_start_d;
   logic        line_start_q, line_start_d;

   logic        h_wrap;
   logic        v_wrap;
   logic        at_origin;
   logic        in_active;

   function automatic logic [2:0] bar_index(input logic [9:0] x);
      logic [2:0] idx;
      if      (x < 10'd80)  idx = 3'd0;
      else if (x < 10'd160) idx = 3'd1;
      else if (x < 10'd240) idx = 3'd2;
      else if (x < 10'd320) idx = 3'd3;
      else if (x < 10'd400) idx = 3'd4;
      else if (x < 10'd480) idx = 3'd5;
      else if (x < 10'd560) idx = 3'd6;
      else                  idx = 3'd7;
      return idx;
   endfunction

   // One bit per component (r,g,b); each bar is either fully on or off per channel.
   function automatic logic [2:0] bar_mask(input logic [2:0] idx);
      logic [2:0] m;
      case (idx)
         3'd0:    m = 3'b111;
         3'd1:    m = 3'b110;
         3'd2:    m = 3'b011;
         3'd3:    m = 3'b010;
         3'd4:    m = 3'b101;
         3'd5:    m = 3'b100;
         3'd6:    m = 3'b001;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic [11:0] expand_mask(input logic [2:0] m);
      return {{4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
   endfunction

   function automatic logic [11:0] pixel_rgb(input logic [1:0] pat,
                                             input logic [9:0] x,
                                             input logic [9:0] y);
      logic [11:0] rgb;
      logic        on_grid;
      on_grid = (x[4:0] == 5'd0) || (y[4:0] == 5'd0) ||
                (x == H_ACTIVE - 10'd1) || (y == V_ACTIVE - 10'd1);
      case (pat)
         PAT_BLACK: rgb = 12'h000;
         PAT_BARS:  rgb = expand_mask(bar_mask(bar_index(x)));
         PAT_WHITE: rgb = 12'hFFF;
         default:   rgb = on_grid ? 12'hFFF : 12'h000;
      endcase
      return rgb;
   endfunction

   always_comb begin
      h_wrap    = (h_cnt_q == H_MAX);
      v_wrap    = (v_cnt_q == V_MAX);
      at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      in_active = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);

      // The (0,0) sample already uses the freshly captured pattern.
      pattern_d = at_origin ? pattern_sel : pattern_q;

      h_cnt_d = 10'd0;
      v_cnt_d = 10'd0;
      if (run) begin
         if (h_wrap) begin
            h_cnt_d = 10'd0;
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
            v_cnt_d = v_cnt_q;
         end
      end

      hsync_d       = 1'b1;
      vsync_d       = 1'b1;
      vde_d         = 1'b0;
      rgb_d         = 12'h000;
      pix_x_d       = 10'd0;
      pix_y_d       = 10'd0;
      frame_start_d = 1'b0;
      line_start_d  = 1'b0;
      if (run) begin
         hsync_d       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
         vsync_d       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
         vde_d         = in_active;
         rgb_d         = in_active ? pixel_rgb(pattern_d, h_cnt_q, v_cnt_q) : 12'h000;
         pix_x_d       = h_cnt_q;
         pix_y_d       = v_cnt_q;
         frame_start_d = at_origin;
         line_start_d  = (h_cnt_q == 10'd0);
      end
   end

   always_ff @(posedge clk_25) begin
      if (rst) begin
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         pattern_q     <= 2'b00;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         vde_q         <= 1'b0;
         rgb_q         <= 12'h000;
         pix_x_q       <= 10'd0;
         pix_y_q       <= 10'd0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pattern_q     <= pattern_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         vde_q         <= vde_d;
         rgb_q         <= rgb_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign vga_vde     = vde_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed scenarios plus randomized run/reset/pattern
// activity, checked against a linear-position reference model of the VGA frame.
module tb_vga_timing_gen;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        vde;
      logic [11:0] rgb;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic        ls;
   } out_t;

   localparam out_t IDLE = '{1'b1, 1'b1, 1'b0, 12'h000, 10'd0, 10'd0, 1'b0, 1'b0};
   localparam int   FRAME = 800 * 525;

   logic       clk_25 = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [1:0] pattern_sel = 2'b00;
   logic       vga_hsync, vga_vsync, vga_vde, frame_start, line_start;
   logic [3:0] vga_r, vga_g, vga_b;
   logic [9:0] pix_x, pix_y;
   out_t       obs;

   int         errors = 0;
   int         checks = 0;
   int         m_pos = 0;
   logic [1:0] m_pat = 2'b00;
   out_t       exp_o = IDLE;
   longint     cyc_n = 0;

   vga_timing_gen dut (
      .clk_25(clk_25), .rst(rst), .run(run), .pattern_sel(pattern_sel),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_vde(vga_vde),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .line_start(line_start)
   );

   always #20 clk_25 = ~clk_25;

   assign obs = {vga_hsync, vga_vsync, vga_vde, vga_r, vga_g, vga_b,
                 pix_x, pix_y, frame_start, line_start};

   // Reference: what the monitor should see for pixel (h, v) of a frame in pattern pat.
   function automatic out_t ref_pixel(input int h, input int v, input logic [1:0] pat);
      out_t o;
      logic [11:0] bars [8];
      bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      o.hs  = !(h >= 656 && h < 656 + 96);
      o.vs  = !(v >= 490 && v < 492);
      o.vde = (h < 640) && (v < 480);
      o.x   = 10'(h);
      o.y   = 10'(v);
      o.fs  = (h == 0) && (v == 0);
      o.ls  = (h == 0);
      o.rgb = 12'h000;
      if (o.vde) begin
         case (pat)
            2'b00: o.rgb = 12'h000;
            2'b01: o.rgb = bars[h / 80];
            2'b10: o.rgb = 12'hFFF;
            default: o.rgb = (h % 32 == 0 || v % 32 == 0 || h == 639 || v == 479) ? 12'hFFF : 12'h000;
         endcase
      end
      return o;
   endfunction

   // Drive one cycle of inputs, advance the model, sample #1 after the edge.
   task automatic step(input logic r, input logic rn, input logic [1:0] ps);
      rst = r;
      run = rn;
      pattern_sel = ps;
      @(posedge clk_25);
      if (r || !rn) begin
         exp_o = IDLE;
         m_pos = 0;
      end else begin
         if (m_pos == 0) m_pat = ps;
         exp_o = ref_pixel(m_pos % 800, m_pos / 800, m_pat);
         m_pos = (m_pos + 1) % FRAME;
      end
      cyc_n++;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 2'($urandom_range(0, 3)));
         checks++;
         if (obs !== IDLE) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, IDLE);
         end
      end
   endtask

   task automatic test_bars();
      logic [11:0] want [8];
      want = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      step(1'b1, 1'b0, 2'b01);
      step(1'b0, 1'b1, 2'b01);
      checks++;
      if (obs.x !== 10'd0 || obs.y !== 10'd0 || obs.vde !== 1'b1 || obs.fs !== 1'b1 || obs.rgb !== 12'hFFF) begin
         errors++;
         $display("FAIL bars_first: got x=%0d y=%0d vde=%b fs=%b rgb=%h expected 0 0 1 1 fff",
                  obs.x, obs.y, obs.vde, obs.fs, obs.rgb);
      end
      for (int i = 1; i < 801; i++) begin
         step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
         checks++;
         if (obs !== exp_o) begin
            errors++;
            $display("FAIL bars_model: got %h expected %h", obs, exp_o);
         end
         if (obs.y == 10'd0 && obs.x < 10'd640 && obs.x % 10'd80 == 10'd40) begin
            checks++;
            if (obs.rgb !== want[obs.x / 10'd80]) begin
               errors++;
               $display("FAIL bar_colour x=%0d: got %h expected %h", obs.x, obs.rgb, want[obs.x / 10'd80]);
            end
         end
         if (i == 80 || i == 560) begin
            checks++;
            if (obs.rgb !== ((i == 80) ? 12'hFF0 : 12'h000)) begin
               errors++;
               $display("FAIL bar_edge x=%0d: got %h", obs.x, obs.rgb);
            end
         end
      end
      checks++;
      if (obs.x !== 10'd0 || obs.y !== 10'd1 || obs.ls !== 1'b1 || obs.fs !== 1'b0) begin
         errors++;
         $display("FAIL second_line: got x=%0d y=%0d ls=%b fs=%b expected 0 1 1 0", obs.x, obs.y, obs.ls, obs.fs);
      end
   endtask

   task automatic test_run_stop();
      bit found = 0;
      step(1'b1, 1'b0, 2'b10);
      for (int i = 0; i < 5000 && !found; i++) begin
         step(1'b0, 1'b1, 2'b10);
         checks++;
         if (obs !== exp_o) begin
            errors++;
            $display("FAIL runstop_model: got %h expected %h", obs, exp_o);
         end
         if (obs.x == 10'd700 && obs.y == 10'd3) found = 1;
      end
      checks++;
      if (!found || obs.hs !== 1'b0) begin
         errors++;
         $display("FAIL runstop_reach: found=%0d hs=%b expected found=1 hs=0", found, obs.hs);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
         checks++;
         if (obs !== IDLE) begin
            errors++;
            $display("FAIL runstop_idle: got %h expected %h", obs, IDLE);
         end
      end
      step(1'b0, 1'b1, 2'b00);
      checks++;
      if (obs.x !== 10'd0 || obs.y !== 10'd0 || obs.fs !== 1'b1 || obs.vde !== 1'b1) begin
         errors++;
         $display("FAIL runstop_restart: got x=%0d y=%0d fs=%b vde=%b expected 0 0 1 1", obs.x, obs.y, obs.fs, obs.vde);
      end
   endtask

   task automatic test_full_frame();
      logic [1:0] pat_in = 2'b10;
      int   frame_idx = 0, fs_cnt = 0, hs_runs = 0, bad_line = 0, bad_hs = 0, bad_white = 0;
      int   vs_low = 0, vs_first_x = -1, vs_first_y = -1, hs_len = 0, hs_start = 0;
      longint fs_at [2];
      longint last_ls = -1;
      bit   switched = 0, done = 0, prev_hs = 1;
      step(1'b1, 1'b0, pat_in);
      for (int n = 0; n < 700000 && !done; n++) begin
         step(1'b0, 1'b1, pat_in);
         if (errors < 40) begin
            checks++;
            if (obs !== exp_o) begin
               errors++;
               $display("FAIL frame_model: got %h expected %h", obs, exp_o);
            end
         end
         if (obs.fs) begin
            if (fs_cnt < 2) fs_at[fs_cnt] = cyc_n;
            fs_cnt++;
            frame_idx++;
         end
         if (obs.ls) begin
            if (last_ls >= 0 && cyc_n - last_ls != 800) bad_line++;
            last_ls = cyc_n;
         end
         if (!obs.hs && prev_hs) begin
            hs_start = int'(obs.x);
            hs_len = 0;
         end
         if (!obs.hs) hs_len++;
         if (obs.hs && !prev_hs) begin
            hs_runs++;
            if (hs_len != 96 || hs_start != 656) bad_hs++;
         end
         prev_hs = obs.hs;
         if (frame_idx == 1 && !obs.vs) begin
            if (vs_low == 0) begin
               vs_first_x = int'(obs.x);
               vs_first_y = int'(obs.y);
            end
            vs_low++;
         end
         if (frame_idx == 1 && switched && obs.vde && obs.rgb !== 12'hFFF) bad_white++;
         if (frame_idx == 1 && obs.x == 10'd100 && obs.y == 10'd200) begin
            pat_in = 2'b11;
            switched = 1;
         end
         if (frame_idx == 1 && ((obs.x == 10'd640 && obs.y == 10'd0) || (obs.x == 10'd0 && obs.y == 10'd480))) begin
            checks++;
            if (obs.vde !== 1'b0 || obs.rgb !== 12'h000) begin
               errors++;
               $display("FAIL blank (%0d,%0d): got vde=%b rgb=%h expected 0 000", obs.x, obs.y, obs.vde, obs.rgb);
            end
         end
         if (frame_idx == 2 && ((obs.x == 10'd0 && obs.y == 10'd5) || (obs.x == 10'd5 && obs.y == 10'd5) ||
                                (obs.x == 10'd639 && obs.y == 10'd100))) begin
            checks++;
            if (obs.rgb !== ((obs.x == 10'd5) ? 12'h000 : 12'hFFF)) begin
               errors++;
               $display("FAIL grid (%0d,%0d): got %h", obs.x, obs.y, obs.rgb);
            end
         end
         if (frame_idx == 2 && obs.x == 10'd300 && obs.y == 10'd300) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout: got done=0 expected 1");
      end
      checks++;
      if (fs_cnt != 2 || fs_at[1] - fs_at[0] != 420000) begin
         errors++;
         $display("FAIL frame_period: got count=%0d delta=%0d expected 2 420000", fs_cnt, fs_at[1] - fs_at[0]);
      end
      checks++;
      if (bad_line != 0 || last_ls < 0) begin
         errors++;
         $display("FAIL line_period: got bad=%0d expected 0", bad_line);
      end
      checks++;
      if (bad_hs != 0 || hs_runs < 800) begin
         errors++;
         $display("FAIL hsync_pulse: got bad=%0d runs=%0d expected 0 >=800", bad_hs, hs_runs);
      end
      checks++;
      if (vs_low != 1600 || vs_first_x != 0 || vs_first_y != 490) begin
         errors++;
         $display("FAIL vsync_pulse: got low=%0d at (%0d,%0d) expected 1600 at (0,490)", vs_low, vs_first_x, vs_first_y);
      end
      checks++;
      if (!switched || bad_white != 0) begin
         errors++;
         $display("FAIL pattern_hold: got switched=%0d non_white=%0d expected 1 0", switched, bad_white);
      end
      step(1'b1, 1'b1, 2'b00);
      checks++;
      if (obs !== IDLE) begin
         errors++;
         $display("FAIL midframe_rst: got %h expected %h", obs, IDLE);
      end
      step(1'b0, 1'b1, 2'b00);
      checks++;
      if (obs.x !== 10'd0 || obs.y !== 10'd0 || obs.fs !== 1'b1 || obs.vde !== 1'b1 || obs.rgb !== 12'h000) begin
         errors++;
         $display("FAIL rst_restart: got x=%0d y=%0d fs=%b vde=%b rgb=%h expected 0 0 1 1 000",
                  obs.x, obs.y, obs.fs, obs.vde, obs.rgb);
      end
   endtask

   task automatic test_random();
      logic       r, rn;
      logic [1:0] ps;
      int         hold = 0;
      ps = 2'b01;
      for (int i = 0; i < 15000; i++) begin
         r  = ($urandom_range(0, 499) == 0);
         if (hold > 0) hold--;
         else if ($urandom_range(0, 299) == 0) hold = $urandom_range(1, 4);
         rn = (hold == 0);
         if ($urandom_range(0, 199) == 0) ps = 2'($urandom_range(0, 3));
         step(r, rn, ps);
         if (errors < 40) begin
            checks++;
            if (obs !== exp_o) begin
               errors++;
               $display("FAIL random_model: got %h expected %h", obs, exp_o);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_bars();
      test_run_stop();
      test_random();
      test_full_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
